// File: rtl/alu_div_32_bits_pkg.sv
// Shared constants, state encoding and operand magnitude helper for the
// 32-bit restoring divider.
package alu_div_32_bits_pkg;

    localparam int          DW       = 32;
    localparam logic [5:0]  CNT_LAST = 6'd31;
    localparam logic [31:0] DZ_Q     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Two's-complement magnitude when the operand is signed and negative.
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic s);
        return (s && v[DW-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/ALU_sub_32_bits.sv
// 32-bit subtractor: s = a - b, UN_N = borrow (a < b unsigned).
module ALU_sub_32_bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s,
    output logic        UN_N
);

    assign {UN_N, s} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/alu_div_32_bits.sv
// Multi-cycle DIV/DIVU: one restoring trial subtraction per cycle, quotient
// to LO (q), remainder to HI (r), sign fix-up in the final state.
module alu_div_32_bits
    import alu_div_32_bits_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sgn,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [DW-1:0] r,
    output logic          dz
);

    state_t        state;
    logic [DW-1:0] a_r, b_r, b_mag, rem, dvd;
    logic          sgn_r, q_neg, r_neg;
    logic [5:0]    cnt;

    logic [DW-1:0] rem_sh, trial, q_fix, r_fix;
    logic          borrow, take;

    // Shift {rem, dvd} left; rem's old MSB is the 33rd bit of the trial value.
    assign rem_sh = {rem[DW-2:0], dvd[DW-1]};
    assign take   = rem[DW-1] | ~borrow;
    assign q_fix  = q_neg ? -dvd : dvd;
    assign r_fix  = r_neg ? -rem : rem;

    ALU_sub_32_bits u_sub (
        .a    (rem_sh),
        .b    (b_mag),
        .s    (trial),
        .UN_N (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            b_mag <= '0;
            rem   <= '0;
            dvd   <= '0;
            sgn_r <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sgn_r <= sgn;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    q_neg <= sgn_r & (a_r[DW-1] ^ b_r[DW-1]);
                    r_neg <= sgn_r & a_r[DW-1];
                    b_mag <= mag(b_r, sgn_r);
                    if (b_r == '0) begin
                        state <= FIX;
                    end else begin
                        rem   <= '0;
                        dvd   <= mag(a_r, sgn_r);
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= take ? trial : rem_sh;
                    dvd <= {dvd[DW-2:0], take};
                    if (cnt == CNT_LAST) state <= FIX;
                    else                 cnt   <= cnt + 6'd1;
                end
                FIX: begin
                    if (b_r == '0) begin
                        q  <= DZ_Q;
                        r  <= a_r;
                        dz <= 1'b1;
                    end else begin
                        q  <= q_fix;
                        r  <= r_fix;
                        dz <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_32_bits.sv
// Directed-vector bench for alu_div_32_bits: results, latency, busy window,
// divide-by-zero, ignored start while busy and mid-operation reset abort.
module tb_alu_div_32_bits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] a, b;
    logic        busy, done, dz;
    logic [31:0] q, r;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_div_32_bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one start pulse and follow the operation until done (or abort).
    // inj >= 0: pulse start with other operands at that cycle.
    // rst_at >= 0: pull rst_n low at that cycle and check the reset outputs.
    task automatic run(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                       input int inj, input int rst_at,
                       output int lat, output int bcnt, output logic [31:0] r_first);
        sgn = s; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 0;
        bcnt    = 0;
        r_first = r;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            if (lat == inj) begin
                start = 1'b1; sgn = 1'b0; a = 32'd10; b = 32'd3;
            end
            if (lat == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_q", q, 32'd0);
                chk("abort_r", r, 32'd0);
                chk("abort_dz", {31'd0, dz}, 32'd0);
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    int          lat, bcnt;
    logic [31:0] rf;

    initial begin
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // DIVU 100 / 7
        run(1'b0, 32'd100, 32'd7, -1, -1, lat, bcnt, rf);
        chk("divu_q", q, 32'd14);
        chk("divu_r", r, 32'd2);
        chk("divu_dz", {31'd0, dz}, 32'd0);
        chk("divu_lat", lat, 32'd34);
        chk("divu_busy_cycles", bcnt, 32'd34);
        chk("divu_busy_after", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("divu_done_pulse", {31'd0, done}, 32'd0);
        chk("divu_q_hold", q, 32'd14);

        // DIV -7 / 2, then 7 / -2 started in the done cycle
        run(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, lat, bcnt, rf);
        chk("div_n7_q", q, 32'hFFFF_FFFD);
        chk("div_n7_r", r, 32'hFFFF_FFFF);
        run(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1, lat, bcnt, rf);
        chk("b2b_r_hold", rf, 32'hFFFF_FFFF);
        chk("b2b_lat", lat, 32'd34);
        chk("div_7_q", q, 32'hFFFF_FFFD);
        chk("div_7_r", r, 32'd1);
        @(posedge clk); #1;

        // signed overflow case
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, lat, bcnt, rf);
        chk("ovf_q", q, 32'h8000_0000);
        chk("ovf_r", r, 32'd0);
        chk("ovf_dz", {31'd0, dz}, 32'd0);
        @(posedge clk); #1;

        // divide by zero
        run(1'b0, 32'h1234_5678, 32'd0, -1, -1, lat, bcnt, rf);
        chk("dz_lat", lat, 32'd2);
        chk("dz_busy_cycles", bcnt, 32'd2);
        chk("dz_q", q, 32'hFFFF_FFFF);
        chk("dz_r", r, 32'h1234_5678);
        chk("dz_flag", {31'd0, dz}, 32'd1);
        @(posedge clk); #1;
        chk("dz_done_pulse", {31'd0, done}, 32'd0);
        chk("dz_flag_hold", {31'd0, dz}, 32'd1);

        // DIVU max / 1 with a start pulse while busy
        run(1'b0, 32'hFFFF_FFFF, 32'd1, 10, -1, lat, bcnt, rf);
        chk("inj_lat", lat, 32'd34);
        chk("inj_q", q, 32'hFFFF_FFFF);
        chk("inj_r", r, 32'd0);
        chk("inj_dz", {31'd0, dz}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("inj_no_rerun", {31'd0, busy}, 32'd0);

        // abort at cycle 20, then a clean 9 / 3
        run(1'b0, 32'd1000, 32'd3, -1, 20, lat, bcnt, rf);
        repeat (2) @(posedge clk);
        #1;
        chk("post_abort_busy", {31'd0, busy}, 32'd0);
        chk("post_abort_done", {31'd0, done}, 32'd0);
        run(1'b0, 32'd9, 32'd3, -1, -1, lat, bcnt, rf);
        chk("rerun_lat", lat, 32'd34);
        chk("rerun_q", q, 32'd3);
        chk("rerun_r", r, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
